// File: rtl/ex_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer for the EX stage.
// Two-cycle multiply, 32-iteration restoring divide, stall/done handshake with the pipeline.
module ex_muldiv_seq #(
    parameter int XLEN     = 32,
    parameter int DIV_ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int CW = $clog2(DIV_ITER);

    logic [2:0]      state;
    logic [CW-1:0]   cnt;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] quo_q, rem_q, dvs_q;
    logic            neg_a, neg_b;
    logic [XLEN-1:0] res_q, result_q;

    logic            div_signed, div_zero, div_ovf;
    logic            a_sgn, b_sgn;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    logic [XLEN-1:0] mul_res;
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] q_fix, r_fix;

    always_comb begin
        div_signed = ~op[0];
        div_zero   = (rs2 == '0);
        div_ovf    = div_signed && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

        // 33x33 signed product, computed modulo 2^64 on sign-extended operands
        a_sgn   = (op_q == 2'b01) || (op_q == 2'b10);
        b_sgn   = (op_q == 2'b01);
        a_ext   = {{XLEN{a_sgn & a_q[XLEN-1]}}, a_q};
        b_ext   = {{XLEN{b_sgn & b_q[XLEN-1]}}, b_q};
        prod    = a_ext * b_ext;
        mul_res = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};

        q_fix = (neg_a ^ neg_b) ? -quo_q : quo_q;
        r_fix = neg_a ? -rem_q : rem_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            res_q    <= '0;
            result_q <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    op_q  <= op[1:0];
                    a_q   <= rs1;
                    b_q   <= rs2;
                    neg_a <= div_signed & rs1[XLEN-1];
                    neg_b <= div_signed & rs2[XLEN-1];
                    quo_q <= (div_signed & rs1[XLEN-1]) ? -rs1 : rs1;
                    dvs_q <= (div_signed & rs2[XLEN-1]) ? -rs2 : rs2;
                    rem_q <= '0;
                    cnt   <= '0;
                    if (!op[2]) begin
                        state <= S_MUL;
                    end else if (div_zero) begin
                        res_q <= op[1] ? rs1 : '1;
                        state <= S_DONE;
                    end else if (div_ovf) begin
                        res_q <= op[1] ? '0 : rs1;
                        state <= S_DONE;
                    end else begin
                        state <= S_DIV;
                    end
                end
                S_MUL: begin
                    res_q <= mul_res;
                    state <= S_DONE;
                end
                S_DIV: begin
                    rem_q <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
                    if (cnt == CW'(DIV_ITER - 1)) begin
                        cnt   <= '0;
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    res_q <= op_q[1] ? r_fix : q_fix;
                    state <= S_DONE;
                end
                S_DONE: begin
                    result_q <= res_q;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // result is committed on leaving DONE so a flush in the DONE cycle leaves the old value visible
    assign done   = (state == S_DONE) & ~flush;
    assign result = done ? res_q : result_q;
    assign stall  = rst & start & (state != S_DONE) & ~flush;

endmodule

// File: doc/ex_muldiv_seq.md
# ex_muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide instructions in the EX stage. It accepts an M-extension operation from the ID/EX register and holds the pipeline with a stall while the operation runs. Multiply takes two cycles; divide and remainder use a 32-iteration restoring divider. The block returns a single-cycle `done` pulse with the 32-bit result, which the EX stage muxes onto the ALU result path into the EX/MEM register.

## Interface
Parameters:
- `XLEN`, 32, operand/result width (only 32 supported)
- `DIV_ITER`, 32, divider iterations (must equal XLEN)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  M-op present in EX; held high by the frozen ID/EX register while `stall` is high
- `op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1`  in  32  dividend / multiplicand (post-forwarding)
- `rs2`  in  32  divisor / multiplier (post-forwarding)
- `flush`  in  1  synchronous abort (branch/jump taken or exception)
- `stall`  out  1  freeze PC, IF/ID, ID/EX; not registered into EX/MEM
- `done`  out  1  one-cycle pulse; `result` valid this cycle
- `result`  out  32  operation result; holds its value until the next `done`

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE: `start` is sampled only in IDLE. On `start`, latch `op`, `rs1`, `rs2`, and the operand signs.
  - Next state is DONE when the special case applies, DIV for divide/remainder ops, and MUL for multiply ops.
- Special cases (DIV/DIVU/REM/REMU), resolved in IDLE:
  - Divisor 0: quotient = 0xFFFFFFFF; remainder = rs1.
  - DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- MUL: form a 33x33 signed product.
  - Operand extension: signed for MULH, rs1 signed / rs2 unsigned for MULHSU, unsigned for MULHU and MUL.
  - Register bits [31:0] for MUL and bits [63:32] for the others, then go to DONE.
- DIV: operate on magnitudes. Take the absolute values of signed operands for DIV/REM; use raw values for DIVU/REMU.
  - Each cycle: shift {rem,quo} left by 1, trial-subtract the divisor, and set the quotient LSB when the difference is non-negative.
  - An iteration counter runs from 0 to 31, then go to FIX.
- FIX: apply signs.
  - Negate the quotient when the operand signs differ (signed ops).
  - Negate the remainder when rs1 was negative (signed ops).
  - Select quotient or remainder by `op[1]`, then go to DONE.
- DONE: `done` = 1 and `result` = the computed value. Next state is IDLE.
- `stall` = `start` & (state != DONE) & ~`flush`. This is combinational, so the instruction advances in the DONE cycle.
- `flush` has priority over everything:
  - In any state, the next state is IDLE.
  - No `done` pulse is produced and the counter is cleared.
  - `result` keeps its prior value.
- `start` in a state other than IDLE is ignored; it is the same instruction, held by the stall.

## Timing
- Reset (`rst` low, asynchronous): state is IDLE, the counter is 0, and `done` = 0, `result` = 0, and `stall` = 0 (forced while in reset).
- With `start` first seen in IDLE at cycle N, `done` occurs at:
  - Special case: N+1.
  - MUL*: N+2.
  - DIV*/REM*: N+34 (32 DIV cycles plus FIX).
- `stall` is high from cycle N through the cycle before `done`, and low in the `done` cycle.
- Back-to-back M-ops: a new op arriving in the cycle after `done` is accepted that cycle (the state is IDLE). Peak throughput is one op per 3 cycles for MUL.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No `done` after release until a new `start`.
- `flush` and `start` in the same IDLE cycle: the op is not accepted and `stall` = 0.

## Test plan
- Reset released, then MUL with rs1 = 7, rs2 = 0xFFFFFFFD (-3) at cycle N: `stall` is high for N and N+1, and at N+2 `done` = 1 with `result` = 0xFFFFFFEB.
- MULH and MULHU on 0x80000000 x 0x80000000: `result` = 0x40000000 for both.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF: `result` = 0xFFFFFFFF.
- DIVU 100/7: `done` at N+34 with `result` = 14.
- REM 0xFFFFFFF9 (-7) by 2: `result` = 0xFFFFFFFF.
- DIV 0xFFFFFFF9 by 2: `result` = 0xFFFFFFFD.
- Special cases, each with `done` at N+1:
  - DIV 5/0: `result` = 0xFFFFFFFF.
  - REMU 5/0: `result` = 5.
  - DIV 0x80000000 / 0xFFFFFFFF: `result` = 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF: `result` = 0.
- `flush` at N+10 of a DIV: no `done`, and `stall` = 0 at N+10. A new DIVU 9/3 started at N+11 gives `done` at N+45 with `result` = 3.
- `rst` pulled low at N+5 of a DIV: all outputs go to 0 immediately. After release, no `done` appears until a new `start`. A back-to-back MUL issued in the cycle after a `done` is accepted and completes 2 cycles later.
